// File: rtl/cpu_defs.sv
// Shared CPU constants: memory map, vectors
// and the next-PC select encoding.
package cpu_defs;

  localparam logic [31:0] CPU_RESET_VEC  = 32'h0000_3000;
  localparam logic [31:0] CPU_EXC_VEC    = 32'h0000_4180;
  localparam logic [31:0] CPU_IMEM_BASE  = 32'h0000_3000;
  localparam logic [31:0] CPU_IMEM_LIMIT = 32'h0000_6FFF;

  localparam logic [2:0] SEL_RESET = 3'd0;
  localparam logic [2:0] SEL_EXC   = 3'd1;
  localparam logic [2:0] SEL_ERET  = 3'd2;
  localparam logic [2:0] SEL_HOLD  = 3'd3;
  localparam logic [2:0] SEL_REDIR = 3'd4;
  localparam logic [2:0] SEL_PEND  = 3'd5;
  localparam logic [2:0] SEL_SEQ   = 3'd6;

endpackage

// File: rtl/fetch_pc_if.sv
// IF-stage PC bundle: control from the pipeline,
// fetch address and status back to it.
interface fetch_pc_if #(
  parameter int WIDTH = 32
);

  logic             stall;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             exc_req;
  logic             eret_req;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] pc_plus8;
  logic             fetch_adel;
  logic             redirect_pending;

  modport master (
    output stall,
    output redirect_valid,
    output redirect_target,
    output exc_req,
    output eret_req,
    output epc,
    input  pc,
    input  pc_plus4,
    input  pc_plus8,
    input  fetch_adel,
    input  redirect_pending
  );

  modport slave (
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    input  exc_req,
    input  eret_req,
    input  epc,
    output pc,
    output pc_plus4,
    output pc_plus8,
    output fetch_adel,
    output redirect_pending
  );

endinterface

// File: rtl/fetch_pc_redirect_buf.sv
// One-entry buffer holding a redirect that
// arrived while IF was stalled.
module pc_redirect_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             consume,
  input  logic             clear,
  input  logic [WIDTH-1:0] tgt_in,
  output logic             pending,
  output logic [WIDTH-1:0] tgt
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0] state;

  // RUN/PEND: capture enters PEND, consume or flush returns to RUN
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= ST_RUN;
    end else if (capture) begin
      state <= ST_PEND;
    end else if (consume) begin
      state <= ST_RUN;
    end
  end

  // latest captured target; a newer capture overwrites it
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt <= '0;
    end else if (capture) begin
      tgt <= tgt_in;
    end
  end

  assign pending = (state == ST_PEND);

endmodule

// File: rtl/fetch_pc.sv
// IF-stage program counter with stall hold,
// redirect buffering and exception vectoring.
module fetch_pc
  import cpu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(CPU_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(CPU_EXC_VEC),
  parameter logic [WIDTH-1:0] IMEM_BASE  = WIDTH'(CPU_IMEM_BASE),
  parameter logic [WIDTH-1:0] IMEM_LIMIT = WIDTH'(CPU_IMEM_LIMIT)
) (
  input logic       clk,
  input logic       reset,
  fetch_pc_if.slave bus
);

  localparam logic [WIDTH-1:0] LAST_WORD =
    IMEM_LIMIT - WIDTH'(3);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pend_tgt;
  logic             pending;
  logic [2:0]       sel;
  logic             capture;
  logic             consume;
  logic             clear;

  // next-PC source, highest priority first
  always_comb begin
    sel = SEL_SEQ;
    if (reset) begin
      sel = SEL_RESET;
    end else if (bus.exc_req) begin
      sel = SEL_EXC;
    end else if (bus.eret_req) begin
      sel = SEL_ERET;
    end else if (bus.stall) begin
      sel = SEL_HOLD;
    end else if (bus.redirect_valid) begin
      sel = SEL_REDIR;
    end else if (pending) begin
      sel = SEL_PEND;
    end
  end

  // next-PC mux driven by the decoded source
  always_comb begin
    pc_nxt = pc_q + WIDTH'(4);
    unique case (1'b1)
      sel == SEL_RESET: pc_nxt = RESET_VEC;
      sel == SEL_EXC:   pc_nxt = EXC_VEC;
      sel == SEL_ERET:  pc_nxt = bus.epc;
      sel == SEL_HOLD:  pc_nxt = pc_q;
      sel == SEL_REDIR: pc_nxt = bus.redirect_target;
      sel == SEL_PEND:  pc_nxt = pend_tgt;
      sel == SEL_SEQ:   pc_nxt = pc_q + WIDTH'(4);
      default:          pc_nxt = pc_q + WIDTH'(4);
    endcase
  end

  assign capture = (sel == SEL_HOLD) && bus.redirect_valid;
  assign consume = (sel == SEL_REDIR) || (sel == SEL_PEND);
  assign clear   = (sel == SEL_EXC) || (sel == SEL_ERET);

  pc_redirect_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .capture (capture),
    .consume (consume),
    .clear   (clear),
    .tgt_in  (bus.redirect_target),
    .pending (pending),
    .tgt     (pend_tgt)
  );

  // PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_nxt;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_plus4         = pc_q + WIDTH'(4);
  assign bus.pc_plus8         = pc_q + WIDTH'(8);
  assign bus.redirect_pending = pending;
  assign bus.fetch_adel       = (pc_q[1:0] != 2'b00)
                              | (pc_q < IMEM_BASE)
                              | (pc_q > LAST_WORD);

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: directed plan steps, then
// random traffic against a rule-level model.
module tb_fetch_pc;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fetch_pc_if #(.WIDTH(32)) bus ();

  fetch_pc #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] m_pc = 32'h0;
  bit          m_pend = 1'b0;
  logic [31:0] m_tgt = 32'h0;

  function automatic bit adel_m(input logic [31:0] p);
    return (p % 4 != 0) || (p < 32'h3000)
        || (p > 32'h6FFF - 3);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit st,
                      input bit rv,
                      input logic [31:0] t,
                      input bit ex, input bit er,
                      input logic [31:0] e);
    @(negedge clk);
    reset = r;
    bus.stall = st;
    bus.redirect_valid = rv;
    bus.redirect_target = t;
    bus.exc_req = ex;
    bus.eret_req = er;
    bus.epc = e;
    if (r) begin
      m_pc = 32'h3000; m_pend = 0;
    end else if (ex) begin
      m_pc = 32'h4180; m_pend = 0;
    end else if (er) begin
      m_pc = e; m_pend = 0;
    end else if (st) begin
      if (rv) begin m_pend = 1; m_tgt = t; end
    end else if (rv) begin
      m_pc = t; m_pend = 0;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    check("pc", bus.pc, m_pc);
    check("pending", {31'b0, bus.redirect_pending},
          {31'b0, m_pend});
    check("plus4", bus.pc_plus4, m_pc + 32'd4);
    check("plus8", bus.pc_plus8, m_pc + 32'd8);
    check("adel", {31'b0, bus.fetch_adel},
          {31'b0, adel_m(m_pc)});
  endtask

  function automatic logic [31:0] rnd_tgt();
    case ($urandom_range(0, 3))
      0: return 32'h3000 + 4 * $urandom_range(0, 4095);
      1: return $urandom();
      2: return 32'h6FF8 + $urandom_range(0, 15);
      default: return 32'hFFFF_FFF0
                    + 4 * $urandom_range(0, 3);
    endcase
  endfunction

  initial begin
    bus.stall = 0;
    bus.redirect_valid = 0;
    bus.redirect_target = 0;
    bus.exc_req = 0;
    bus.eret_req = 0;
    bus.epc = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_pc", bus.pc, 32'h3000);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("seq_pc", bus.pc, 32'h300C);
    check("seq_p8", bus.pc_plus8, 32'h3014);
    step(0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 1, 32'h3100, 0, 0, 0);
    check("hold_pc", bus.pc, 32'h3010);
    check("hold_pend", {31'b0, bus.redirect_pending},
          32'd1);
    step(0, 1, 0, 0, 0, 0, 0);
    check("hold2_pc", bus.pc, 32'h3010);
    step(0, 0, 0, 0, 0, 0, 0);
    check("pend_go", bus.pc, 32'h3100);

    step(0, 1, 1, 32'h3100, 0, 0, 0);
    step(0, 1, 1, 32'h3200, 0, 0, 0);
    step(0, 0, 1, 32'h3300, 0, 0, 0);
    check("live_wins", bus.pc, 32'h3300);
    step(0, 0, 0, 0, 0, 0, 0);
    check("buf_gone", bus.pc, 32'h3304);

    step(0, 1, 1, 32'h3400, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    check("exc_pc", bus.pc, 32'h4180);
    check("exc_pend", {31'b0, bus.redirect_pending},
          32'd0);
    step(0, 0, 0, 0, 0, 1, 32'h3020);
    check("eret_pc", bus.pc, 32'h3020);
    step(0, 0, 0, 0, 1, 1, 32'h3040);
    check("exc_over_eret", bus.pc, 32'h4180);

    step(0, 0, 1, 32'h3002, 0, 0, 0);
    check("adel_mis", {31'b0, bus.fetch_adel}, 32'd1);
    step(0, 0, 1, 32'h7000, 0, 0, 0);
    check("adel_hi", {31'b0, bus.fetch_adel}, 32'd1);
    step(0, 0, 1, 32'h6FFC, 0, 0, 0);
    check("adel_top", {31'b0, bus.fetch_adel}, 32'd0);
    step(0, 0, 1, 32'h2FFC, 0, 0, 0);
    check("adel_lo", {31'b0, bus.fetch_adel}, 32'd1);

    step(0, 1, 1, 32'h3500, 0, 0, 0);
    step(1, 1, 1, 32'h3600, 1, 0, 0);
    check("rst_pend_pc", bus.pc, 32'h3000);
    check("rst_pend", {31'b0, bus.redirect_pending},
          32'd0);

    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    check("wrap_p4", bus.pc_plus4, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", bus.pc, 32'h0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 30,
           rnd_tgt(),
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 4,
           rnd_tgt());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
